uart_stream_tx: RTL and testbench

- Return path for the DAC board: buffers 8-bit capture or telemetry samples in an internal FIFO and transmits them to the host as UART 8N1.
- Honours host flow control (cts_n) so the host can throttle the stream.
- Counterpart of the RX→FIFO→DAC playback chain; its bit timing matches rxuart at the same CLOCK_DIVIDE.

---
 rtl/uart_stream_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_stream_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_tx.sv
// uart_stream_tx: byte FIFO feeding a UART 8N1 transmitter, paced by host cts_n.
// The bit timing is the same as rxuart when both use the same CLOCK_DIVIDE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line high; start a frame when FIFO has data and cts is clear
// S_START | start bit (tx=0) for BIT_CLKS cycles
// S_DATA  | 8 data bits, LSB first, BIT_CLKS cycles each
// S_STOP  | stop bit (tx=1) for BIT_CLKS cycles, then back to S_IDLE
module uart_stream_tx #(
    parameter int CLOCK_DIVIDE = 13,
    parameter int FIFO_SIZE    = 256,
    parameter int FILL_BITS    = $clog2(FIFO_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 cts_n,
    input  logic                 ovf_clr,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [FILL_BITS-1:0] fill,
    output logic                 overflow
);

    localparam int BIT_CLKS = 4 * CLOCK_DIVIDE;
    localparam int PTR_W    = $clog2(FIFO_SIZE);
    localparam int BAUD_W   = $clog2(BIT_CLKS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]        mem [FIFO_SIZE];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        sh;
    logic              cts_sync1;
    logic              cts_sync2;
    logic              cts_ok;
    logic              push;
    logic              pop;

    // FIFO status and the push/pop qualifiers; full is judged before any same-cycle pop
    always_comb begin
        fifo_empty = (fill == '0);
        fifo_full  = (fill == FILL_BITS'(FIFO_SIZE));
        cts_ok     = !cts_sync2;
        push       = wr_en && !fifo_full;
        pop        = (state == S_IDLE) && !fifo_empty && cts_ok;
        busy       = (state != S_IDLE);
    end

    // Two-flop synchroniser for the asynchronous host cts_n; resets to "not clear"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_sync1 <= 1'b1;
            cts_sync2 <= 1'b1;
        end else begin
            cts_sync1 <= cts_n;
            cts_sync2 <= cts_sync1;
        end
    end

    // FIFO storage; contents need no reset since fill gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and fill count; pointers wrap naturally at FIFO_SIZE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_BITS'(1);
                2'b01:   fill <= fill - FILL_BITS'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Frame sequencer; tx is registered so reset forces the line high without a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        sh       <= mem[rd_ptr];
                        tx       <= 1'b0;
                        baud_cnt <= BAUD_W'(BIT_CLKS - 1);
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        tx       <= sh[0];
                        bit_cnt  <= '0;
                        baud_cnt <= BAUD_W'(BIT_CLKS - 1);
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_W'(BIT_CLKS - 1);
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            sh      <= {1'b0, sh[7:1]};
                            tx      <= sh[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: directed steps with random payloads, checked against a
// byte-queue model and a line-level UART decoder that knows nothing of the RTL states.
module tb_uart_stream_tx;

    localparam int CD       = 3;
    localparam int FSIZE    = 256;
    localparam int FB       = $clog2(FSIZE) + 1;
    localparam int BIT      = 4 * CD;
    localparam int FRAME    = 10 * BIT;
    localparam int SPACING  = FRAME + 1;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          cts_n;
    logic          ovf_clr;
    logic          tx;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [FB-1:0] fill;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_cnt = 0;

    logic [7:0] ref_q[$];
    logic [7:0] dec_byte[$];
    logic       dec_stop[$];
    int         dec_t[$];

    uart_stream_tx #(.CLOCK_DIVIDE(CD), .FIFO_SIZE(FSIZE), .FILL_BITS(FB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .cts_n      (cts_n),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fill       (fill),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge reset_n) rst_cnt <= rst_cnt + 1;

    // Line decoder: find a falling edge, sample each bit at its centre
    initial begin : decoder
        logic       last_tx;
        logic [7:0] d;
        logic       stop_b;
        int         t0;
        int         r0;
        last_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && last_tx === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                r0 = rst_cnt;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                stop_b = tx;
                if (rst_cnt == r0 && reset_n === 1'b1) begin
                    dec_byte.push_back(d);
                    dec_stop.push_back(stop_b);
                    dec_t.push_back(t0);
                end
            end
            last_tx = tx;
        end
    end

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            wr_en   = 1'b1;
            wr_data = bytes[i];
            if (ref_q.size() < FSIZE) ref_q.push_back(bytes[i]);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        while ((busy !== 1'b0 || fifo_empty !== 1'b1) && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, k < bound, 1'b1);
    endtask

    task automatic wait_tx_low(input string tag, input int bound, output int k);
        k = 0;
        while (tx !== 1'b0 && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, k < bound, 1'b1);
    endtask

    task automatic consume(input string tag, output int t);
        logic [7:0] exp;
        t = 0;
        check({tag, "_present"}, dec_byte.size() > 0 && ref_q.size() > 0, 1'b1);
        if (dec_byte.size() > 0 && ref_q.size() > 0) begin
            exp = ref_q.pop_front();
            t   = dec_t.pop_front();
            check({tag, "_data"}, dec_byte.pop_front(), exp);
            check({tag, "_stop"}, dec_stop.pop_front(), 1'b1);
        end
    endtask

    initial begin : stim
        logic [7:0] b[$];
        int t[4];
        int k;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        cts_n   = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fill", fill, 0);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: single byte, latency and frame length
        wr_en = 1'b1; wr_data = 8'hA5; ref_q.push_back(8'hA5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("t1_tx_before", tx, 1'b1);
        @(posedge clk); #1;
        check("t1_tx_fall", tx, 1'b0);
        check("t1_busy", busy, 1'b1);
        k = 0;
        while (busy === 1'b1 && k < 2 * FRAME) begin
            @(posedge clk); #1;
            k++;
        end
        check("t1_busy_len", k, FRAME);
        check("t1_fill", fill, 0);
        consume("t1", t[0]);

        // 2: three back-to-back bytes
        b = '{8'h00, 8'hFF, 8'h55};
        burst(b);
        check("t2_fill_peak", fill, 2);
        wait_idle("t2_idle", 4 * SPACING);
        for (int i = 0; i < 3; i++) consume("t2", t[i]);
        check("t2_space01", t[1] - t[0], SPACING);
        check("t2_space12", t[2] - t[1], SPACING);

        // 3: flow control holds the stream
        cts_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        b = {};
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        burst(b);
        repeat (20) @(posedge clk); #1;
        check("t3_tx_held", tx, 1'b1);
        check("t3_fill", fill, 4);
        check("t3_no_frame", dec_byte.size(), 0);
        cts_n = 1'b0;
        wait_tx_low("t3_start_seen", 10, k);
        check("t3_start_quick", k <= 4, 1'b1);
        wait_idle("t3_idle", 5 * SPACING);
        for (int i = 0; i < 4; i++) consume("t3", t[0]);

        // 4: fill to capacity, drop one, clear overflow, drain
        cts_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        b = {};
        for (int i = 0; i < FSIZE + 1; i++) b.push_back(8'($urandom));
        burst(b);
        check("t4_full", fifo_full, 1'b1);
        check("t4_fill", fill, FSIZE);
        check("t4_ovf_set", overflow, 1'b1);
        check("t4_model_len", ref_q.size(), FSIZE);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("t4_ovf_clr", overflow, 1'b0);
        cts_n = 1'b0;
        wait_idle("t4_idle", FSIZE * SPACING + 200);
        repeat (2 * SPACING) @(posedge clk); #1;
        check("t4_frame_count", dec_byte.size(), FSIZE);
        for (int i = 0; i < FSIZE; i++) consume("t4", t[0]);

        // 5: reset in the middle of bit 3 of 0x3C
        b = '{8'h3C, 8'($urandom)};
        burst(b);
        wait_tx_low("t5_start_seen", 10, k);
        repeat (4 * BIT + BIT / 2) @(posedge clk); #1;
        check("t5_busy_pre", busy, 1'b1);
        check("t5_fill_pre", fill, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1'b1);
        check("t5_busy_async", busy, 1'b0);
        check("t5_fill_async", fill, 0);
        check("t5_empty_async", fifo_empty, 1'b1);
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1;
        ref_q.delete();
        repeat (3 * SPACING) @(posedge clk); #1;
        check("t5_no_stale", dec_byte.size(), 0);
        check("t5_tx_idle", tx, 1'b1);
        check("t5_busy_idle", busy, 1'b0);

        // 6: cts raised during start bit withholds the second frame
        b = '{8'($urandom), 8'($urandom)};
        burst(b);
        wait_tx_low("t6_start_seen", 10, k);
        repeat (3) @(posedge clk); #1;
        cts_n = 1'b1;
        k = 0;
        while (busy === 1'b1 && k < 2 * FRAME) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_frame1_ends", k < 2 * FRAME, 1'b1);
        consume("t6_f1", t[0]);
        repeat (2 * SPACING) @(posedge clk); #1;
        check("t6_withheld_busy", busy, 1'b0);
        check("t6_withheld_fill", fill, 1);
        check("t6_withheld_tx", tx, 1'b1);
        cts_n = 1'b0;
        wait_idle("t6_idle", 2 * SPACING);
        consume("t6_f2", t[0]);
        check("t6_ovf", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
